store_narrow_unit: RTL

Store-path data formatter for the MIPS datapath, the write-side counterpart of load sign/zero extension. It narrows a 32-bit register value to a byte, halfword or word, positions it on the correct byte lanes of a word-addressed data memory with matching byte enables, and drives the memory write through a valid/ready handshake. It sits between the execute stage's store request and the data-memory port, and reports completion or a misalignment fault per request.

---
 rtl/store_narrow_unit.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/store_narrow_unit.sv
`default_nettype none
// ============================================================================
// Module   : store_narrow_unit
// Function : Narrows a store to byte/half/word, places it on memory byte lanes
//            with byte enables and writes it over a valid/ready port.
//            Optional macro STORE_SPLIT_EN allows misaligned stores (split).
// Revision : 1.0
// ============================================================================
module store_narrow_unit #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_data,
    input  logic [1:0]        req_size,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_be,
    output logic              done,
    output logic              misalign
);

`ifdef STORE_SPLIT_EN
    localparam logic c_SPLIT_EN = 1'b1;
`else
    localparam logic c_SPLIT_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BEAT0 = 2'd1,
        S_BEAT1 = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t            r_state;
    logic              r_two;
    logic [ADDR_W-1:0] r_hi_addr;
    logic [31:0]       r_hi_data;
    logic [3:0]        r_hi_be;

    logic [1:0]        w_off;
    logic [3:0]        w_mask;
    logic [31:0]       w_masked;
    logic [63:0]       w_shift;
    logic [7:0]        w_be8;
    logic              w_aligned;
    logic              w_fault;
    logic              w_two;
    logic [ADDR_W-1:0] w_addr0;
    logic [ADDR_W-1:0] w_addr1;

    always_comb begin
        w_off     = req_addr[1:0];
        w_mask    = 4'b1111;
        w_masked  = req_data;
        w_aligned = 1'b0;
        case (req_size)
            2'b00: begin
                w_mask    = 4'b0001;
                w_masked  = {24'b0, req_data[7:0]};
                w_aligned = 1'b1;
            end
            2'b01: begin
                w_mask    = 4'b0011;
                w_masked  = {16'b0, req_data[15:0]};
                w_aligned = ~w_off[0];
            end
            2'b10: begin
                w_aligned = (w_off == 2'b00);
            end
            default: begin
                w_aligned = 1'b0;
            end
        endcase
        w_shift = {32'b0, w_masked} << {w_off, 3'b000};
        w_be8   = {4'b0, w_mask} << w_off;
        // Reserved size always faults; misalignment faults only without splitting
        w_fault = (req_size == 2'b11) || (!w_aligned && !c_SPLIT_EN);
        w_two   = c_SPLIT_EN && (w_be8[7:4] != 4'b0000);
        w_addr0 = {req_addr[ADDR_W-1:2], 2'b00};
        w_addr1 = w_addr0 + ADDR_W'(4);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_two     <= 1'b0;
            r_hi_addr <= '0;
            r_hi_data <= '0;
            r_hi_be   <= '0;
            req_ready <= 1'b1;
            mem_valid <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
            done      <= 1'b0;
            misalign  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        if (w_fault) begin
                            misalign <= 1'b1;
                            r_state  <= S_RESP;
                        end else begin
                            mem_valid <= 1'b1;
                            mem_addr  <= w_addr0;
                            mem_wdata <= w_shift[31:0];
                            mem_be    <= w_be8[3:0];
                            r_two     <= w_two;
                            r_hi_addr <= w_addr1;
                            r_hi_data <= w_shift[63:32];
                            r_hi_be   <= w_be8[7:4];
                            r_state   <= S_BEAT0;
                        end
                    end
                end
                S_BEAT0: begin
                    if (mem_ready) begin
                        if (r_two) begin
                            mem_addr  <= r_hi_addr;
                            mem_wdata <= r_hi_data;
                            mem_be    <= r_hi_be;
                            r_state   <= S_BEAT1;
                        end else begin
                            mem_valid <= 1'b0;
                            mem_addr  <= '0;
                            mem_wdata <= '0;
                            mem_be    <= '0;
                            done      <= 1'b1;
                            r_state   <= S_RESP;
                        end
                    end
                end
                S_BEAT1: begin
                    if (mem_ready) begin
                        mem_valid <= 1'b0;
                        mem_addr  <= '0;
                        mem_wdata <= '0;
                        mem_be    <= '0;
                        done      <= 1'b1;
                        r_state   <= S_RESP;
                    end
                end
                default: begin
                    done      <= 1'b0;
                    misalign  <= 1'b0;
                    req_ready <= 1'b1;
                    r_two     <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
